// File: rtl/knn_pkg.sv
// Shared types and default sizing for the KNN query sequencer slice.
package knn_pkg;

  typedef enum logic [2:0] {IDLE, STREAM, DRAIN, WAIT, RESP} state_t;

  // Width of a counter that must hold values 0..max_val.
  function automatic int unsigned ctr_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned FEATURES_DEF   = 8;
  localparam int unsigned MAX_TRAIN_DEF  = 64;
  localparam int unsigned TIMEOUT_DEF    = 255;

  localparam int unsigned VW = DATA_WIDTH_DEF * FEATURES_DEF;
  localparam int unsigned CW = $clog2(MAX_TRAIN_DEF) + 1;
  localparam int unsigned TW = ctr_width(TIMEOUT_DEF);

endpackage

// File: rtl/knn_query_sequencer_if.sv
// Sequencer <-> distance/comparator datapath bus.
interface knn_query_sequencer_if
  import knn_pkg::*;
#(
  parameter int unsigned VEC_W = VW
);
  logic [VEC_W-1:0] train_data;
  logic             train_label;
  logic             data_valid;
  logic             training_done;
  logic [VEC_W-1:0] test_data;
  logic             pred_valid;
  logic             pred_label;

  modport master (
    output train_data, train_label, data_valid, training_done, test_data,
    input  pred_valid, pred_label
  );

  modport slave (
    input  train_data, train_label, data_valid, training_done, test_data,
    output pred_valid, pred_label
  );
endinterface

// File: rtl/knn_train_buffer.sv
// Training sample store: one synchronous write port, one combinational read port.
module knn_train_buffer #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/knn_query_sequencer.sv
// Owns the KNN datapath: streams the stored training set for each query,
// drains the pipeline, then returns the predicted label (or an error).
module knn_query_sequencer
  import knn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FEATURES   = 8,
  parameter int unsigned MAX_TRAIN  = 64,
  parameter int unsigned PIPE_LAT   = 2,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr_i,
  input  logic                             ld_valid_i,
  output logic                             ld_ready_o,
  input  logic [DATA_WIDTH*FEATURES-1:0]   ld_data_i,
  input  logic                             ld_label_i,
  input  logic                             q_valid_i,
  output logic                             q_ready_o,
  input  logic [DATA_WIDTH*FEATURES-1:0]   q_data_i,
  output logic                             res_valid_o,
  input  logic                             res_ready_i,
  output logic                             res_label_o,
  output logic                             res_err_o,
  knn_query_sequencer_if.master            dp,
  output logic [$clog2(MAX_TRAIN):0]       train_count_o,
  output logic                             busy_o
);

  localparam int unsigned VEC_W = DATA_WIDTH * FEATURES;
  localparam int unsigned AW    = $clog2(MAX_TRAIN);
  localparam int unsigned CNT_W = AW + 1;
  localparam int unsigned TO_W  = ctr_width(TIMEOUT);
  localparam int unsigned DR_W  = ctr_width(PIPE_LAT);

  state_t           state, state_n;
  logic [CNT_W-1:0] count, count_n, last_idx;
  logic [AW-1:0]    rd_idx, rd_idx_n;
  logic [DR_W-1:0]  drain_cnt, drain_cnt_n;
  logic [TO_W-1:0]  to_cnt, to_cnt_n;
  logic [VEC_W-1:0] test_q, test_n;
  logic             res_label, res_label_n, res_err, res_err_n;
  logic             idle, ld_fire, q_fire;
  logic [VEC_W:0]   rd_word;

  knn_train_buffer #(.DEPTH(MAX_TRAIN), .WIDTH(VEC_W + 1)) u_buf (
    .clk   (clk),
    .we    (ld_fire),
    .waddr (count[AW-1:0]),
    .wdata ({ld_label_i, ld_data_i}),
    .raddr (rd_idx),
    .rdata (rd_word)
  );

  // Handshakes are gated by rst so every output reads 0 while reset is held.
  assign idle       = (state == IDLE);
  assign ld_ready_o = idle && !rst && !clr_i && (count < CNT_W'(MAX_TRAIN));
  assign q_ready_o  = idle && !rst && !clr_i && !ld_valid_i;
  assign ld_fire    = ld_valid_i && ld_ready_o;
  assign q_fire     = q_valid_i && q_ready_o;
  assign last_idx   = count - 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      rd_idx    <= '0;
      drain_cnt <= '0;
      to_cnt    <= '0;
      test_q    <= '0;
      res_label <= 1'b0;
      res_err   <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      rd_idx    <= rd_idx_n;
      drain_cnt <= drain_cnt_n;
      to_cnt    <= to_cnt_n;
      test_q    <= test_n;
      res_label <= res_label_n;
      res_err   <= res_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    count_n     = count;
    rd_idx_n    = rd_idx;
    drain_cnt_n = drain_cnt;
    to_cnt_n    = to_cnt;
    test_n      = test_q;
    res_label_n = res_label;
    res_err_n   = res_err;
    unique case (state)
      IDLE: begin
        if (clr_i)        count_n = '0;
        else if (ld_fire) count_n = count + 1'b1;
        if (q_fire) begin
          test_n   = q_data_i;
          rd_idx_n = '0;
          if (count == '0) begin
            res_err_n   = 1'b1;
            res_label_n = 1'b0;
            state_n     = RESP;
          end else begin
            state_n = STREAM;
          end
        end
      end
      STREAM: begin
        // rd_idx stops at count-1 instead of incrementing, so a full buffer never wraps it.
        if ({1'b0, rd_idx} == last_idx) begin
          rd_idx_n    = '0;
          drain_cnt_n = '0;
          to_cnt_n    = '0;
          state_n     = (PIPE_LAT == 0) ? WAIT : DRAIN;
        end else begin
          rd_idx_n = rd_idx + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt == DR_W'(PIPE_LAT - 1)) begin
          to_cnt_n = '0;
          state_n  = WAIT;
        end else begin
          drain_cnt_n = drain_cnt + 1'b1;
        end
      end
      WAIT: begin
        if (dp.pred_valid) begin
          res_label_n = dp.pred_label;
          res_err_n   = 1'b0;
          state_n     = RESP;
        end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          res_label_n = 1'b0;
          res_err_n   = 1'b1;
          state_n     = RESP;
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end
      RESP: begin
        if (res_ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign dp.data_valid    = (state == STREAM);
  assign dp.train_data    = (state == STREAM) ? rd_word[VEC_W-1:0] : '0;
  assign dp.train_label   = (state == STREAM) ? rd_word[VEC_W] : 1'b0;
  assign dp.training_done = (state == WAIT) && (to_cnt == '0);
  assign dp.test_data     = test_q;

  assign res_valid_o   = (state == RESP);
  assign res_label_o   = res_label;
  assign res_err_o     = res_err;
  assign train_count_o = count;
  assign busy_o        = !idle;

endmodule

// File: tb/tb_knn_query_sequencer.sv
// Directed bench for knn_query_sequencer; the bench plays the datapath role.
module tb_knn_query_sequencer;
  import knn_pkg::*;

  localparam int unsigned MAXT = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr, ld_valid, ld_label, q_valid, res_ready;
  logic [VW-1:0] ld_data, q_data;
  logic          ld_ready, q_ready, res_valid, res_label, res_err, busy;
  logic [CW-1:0] train_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [VW-1:0] mdata [MAXT];
  logic          mlab  [MAXT];
  int            mcount = 0;

  knn_query_sequencer_if #(.VEC_W(VW)) dp_if ();

  knn_query_sequencer #(
    .DATA_WIDTH (8),
    .FEATURES   (8),
    .MAX_TRAIN  (MAXT),
    .PIPE_LAT   (2),
    .TIMEOUT    (255)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clr_i         (clr),
    .ld_valid_i    (ld_valid),
    .ld_ready_o    (ld_ready),
    .ld_data_i     (ld_data),
    .ld_label_i    (ld_label),
    .q_valid_i     (q_valid),
    .q_ready_o     (q_ready),
    .q_data_i      (q_data),
    .res_valid_o   (res_valid),
    .res_ready_i   (res_ready),
    .res_label_o   (res_label),
    .res_err_o     (res_err),
    .dp            (dp_if),
    .train_count_o (train_count),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expected);
    n_checks++;
    if (obs !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expected);
    end
  endtask

  task automatic load_word(input logic [VW-1:0] d, input logic l);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_label = l;
    mdata[mcount] = d;
    mlab[mcount]  = l;
    mcount++;
  endtask

  task automatic load_stop();
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic clear_set();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    mcount = 0;
  endtask

  // Presents one query, then acts as the datapath until res_valid rises.
  task automatic run_query(input logic [VW-1:0] qd, input bit answer, input logic lbl,
                           output int done_at, output int res_at, output int vcnt,
                           output int dcnt, output int bad, output logic qr);
    done_at = -1; res_at = -1; vcnt = 0; dcnt = 0; bad = 0;
    @(negedge clk);
    ld_valid = 1'b0;
    q_valid  = 1'b1;
    q_data   = qd;
    #1 qr = q_ready;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      q_valid          = 1'b0;
      dp_if.pred_valid = 1'b0;
      if (dp_if.test_data !== qd) bad++;
      if (dp_if.data_valid === 1'b1) begin
        if (vcnt >= mcount || dp_if.train_data !== mdata[vcnt] || dp_if.train_label !== mlab[vcnt])
          bad++;
        vcnt++;
      end
      if (dp_if.training_done === 1'b1) begin
        dcnt++;
        if (done_at < 0) done_at = k;
        if (answer) begin
          dp_if.pred_valid = 1'b1;
          dp_if.pred_label = lbl;
        end
      end
      if (res_valid === 1'b1) begin
        res_at = k;
        break;
      end
    end
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_eq(tag, {62'd0, res_valid, busy}, 64'd0);
  endtask

  int   da, ra, vc, dc, bd, cnt;
  logic qr;

  initial begin
    clr = 0; ld_valid = 0; ld_label = 0; q_valid = 0; res_ready = 0;
    ld_data = '0; q_data = '0;
    dp_if.pred_valid = 1'b0;
    dp_if.pred_label = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_ctrl", {56'd0, busy, res_valid, res_label, res_err, ld_ready, q_ready,
                          dp_if.data_valid, dp_if.training_done}, 64'd0);
    check_eq("rst_count", 64'(train_count), 64'd0);
    check_eq("rst_test_data", dp_if.test_data, 64'd0);
    check_eq("rst_train_data", {dp_if.train_label, dp_if.train_data[62:0]}, 64'd0);
    rst = 1'b0;

    // Three samples, labels 1,0,1, datapath answers 1
    for (int i = 0; i < 3; i++) load_word(64'h9E37_79B9_7F4A_7C15 * 64'(i + 1), (i != 1));
    load_stop();
    check_eq("t1_count", 64'(train_count), 64'd3);
    run_query(64'hDEAD_BEEF_0000_0001, 1'b1, 1'b1, da, ra, vc, dc, bd, qr);
    check_eq("t1_q_ready", 64'(qr), 64'd1);
    check_eq("t1_valid_cycles", 64'(vc), 64'd3);
    check_eq("t1_stream_order", 64'(bd), 64'd0);
    check_eq("t1_done_cycle", 64'(da), 64'd6);
    check_eq("t1_done_pulses", 64'(dc), 64'd1);
    check_eq("t1_res_cycle", 64'(ra), 64'd7);
    check_eq("t1_result", {62'd0, res_label, res_err}, 64'b10);
    release_result("t1_release");

    // Empty training set
    @(negedge clk);
    clr = 1'b1;
    #1 check_eq("clr_ld_ready", 64'(ld_ready), 64'd0);
    @(negedge clk);
    clr = 1'b0;
    mcount = 0;
    check_eq("clr_count", 64'(train_count), 64'd0);
    run_query(64'h0000_1111_2222_3333, 1'b1, 1'b1, da, ra, vc, dc, bd, qr);
    check_eq("t2_res_cycle", 64'(ra), 64'd1);
    check_eq("t2_no_stream", 64'(vc), 64'd0);
    check_eq("t2_no_done", 64'(dc), 64'd0);
    check_eq("t2_result", {62'd0, res_label, res_err}, 64'b01);
    release_result("t2_release");

    // Timeout, then a normal query
    load_word(64'h0F0F_0F0F_F0F0_F0F0, 1'b1);
    load_stop();
    run_query(64'h5555_AAAA_5555_AAAA, 1'b0, 1'b0, da, ra, vc, dc, bd, qr);
    check_eq("t3_done_cycle", 64'(da), 64'd4);
    check_eq("t3_timeout_gap", 64'(ra - da), 64'd255);
    check_eq("t3_result", {62'd0, res_label, res_err}, 64'b01);
    release_result("t3_release");
    run_query(64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1, da, ra, vc, dc, bd, qr);
    check_eq("t3b_res_cycle", 64'(ra), 64'd5);
    check_eq("t3b_result", {62'd0, res_label, res_err}, 64'b10);
    release_result("t3b_release");

    // Fill the buffer to MAX_TRAIN
    clear_set();
    for (int i = 0; i < MAXT; i++) load_word({32'(i), 32'hC0DE_0000 ^ 32'(i * 7)}, i[0]);
    @(negedge clk);
    ld_data = '1;
    #1 check_eq("t4_full_ld_ready", 64'(ld_ready), 64'd0);
    check_eq("t4_full_count", 64'(train_count), 64'd64);
    load_stop();
    run_query(64'hFFFF_0000_FFFF_0000, 1'b1, 1'b0, da, ra, vc, dc, bd, qr);
    check_eq("t4_q_ready_full", 64'(qr), 64'd1);
    check_eq("t4_valid_cycles", 64'(vc), 64'd64);
    check_eq("t4_stream_order", 64'(bd), 64'd0);
    check_eq("t4_done_cycle", 64'(da), 64'd67);
    check_eq("t4_result", {62'd0, res_label, res_err}, 64'b00);
    release_result("t4_release");
    clear_set();
    check_eq("t4_clr_count", 64'(train_count), 64'd0);

    // Load and query together; held result
    @(negedge clk);
    ld_valid = 1'b1; ld_data = 64'hABCD_0000_1234_0000; ld_label = 1'b1;
    mdata[0] = ld_data; mlab[0] = 1'b1; mcount = 1;
    q_valid = 1'b1; q_data = 64'h0707_0707_0707_0707;
    #1 check_eq("t5_q_blocked", {62'd0, ld_ready, q_ready}, 64'b10);
    run_query(64'h0707_0707_0707_0707, 1'b1, 1'b1, da, ra, vc, dc, bd, qr);
    check_eq("t5_q_ready_next", 64'(qr), 64'd1);
    check_eq("t5_count", 64'(train_count), 64'd1);
    check_eq("t5_res_cycle", 64'(ra), 64'd5);
    check_eq("t5_stream", 64'(bd), 64'd0);
    cnt = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      dp_if.pred_valid = j[0];
      dp_if.pred_label = 1'b0;
      if (!(res_valid === 1'b1 && res_label === 1'b1 && res_err === 1'b0)) cnt++;
    end
    dp_if.pred_valid = 1'b0;
    check_eq("t5_hold_stable", 64'(cnt), 64'd0);
    release_result("t5_release");

    // Reset during STREAM
    for (int i = 0; i < 3; i++) load_word(64'h1111_0000_0000_0000 * 64'(i + 1), 1'b1);
    load_stop();
    @(negedge clk);
    q_valid = 1'b1; q_data = 64'h0BAD_F00D_0BAD_F00D;
    @(negedge clk);
    q_valid = 1'b0;
    check_eq("t6_streaming", 64'(dp_if.data_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_rst_ctrl", {56'd0, busy, res_valid, res_label, res_err, ld_ready, q_ready,
                             dp_if.data_valid, dp_if.training_done}, 64'd0);
    check_eq("t6_rst_count", 64'(train_count), 64'd0);
    check_eq("t6_rst_test_data", dp_if.test_data, 64'd0);
    check_eq("t6_rst_train_data", dp_if.train_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mcount = 0;
    @(negedge clk);
    check_eq("t6_idle_after", {62'd0, busy, ld_ready}, 64'b01);
    cnt = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (dp_if.data_valid !== 1'b0 || dp_if.training_done !== 1'b0 || res_valid !== 1'b0) cnt++;
    end
    check_eq("t6_aborted", 64'(cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
